// File: rtl/spi_slave_regif.sv
// spi_slave_regif: mode-0 SPI responder decoding command frames into register write strobes and read requests
module spi_slave_regif #(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  wr_vld,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  frame_err
);
    localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] LAST_CMD = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

    typedef enum logic [2:0] {IDLE, CMD, W_DATA, R_LOAD, R_DATA, DONE} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s, rise, fall, cs_fall, cs_rise;
    logic [CW-1:0]          cnt;
    logic [ADDR_WIDTH-1:0]  cmd;
    logic [ADDR_WIDTH:0]    next_cmd;
    logic [DATA_WIDTH-2:0]  wsh;
    logic [DATA_WIDTH-1:0]  next_w, rsh;
    logic [1:0]             lph;

    assign sclk_s   = sclk_q[SYNC_STAGES-1];
    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_d;
    assign fall     = ~sclk_s & sclk_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign next_cmd = {cmd, mosi_s};
    assign next_w   = {wsh, mosi_s};

    // CS syncs from 0 so a CS held low through reset never produces a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd       <= '0;
            wsh       <= '0;
            rsh       <= '0;
            lph       <= '0;
            miso      <= 1'b0;
            wr_vld    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_vld    <= 1'b0;
            rd_req    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (cs_fall) begin
                    state <= CMD;
                    cnt   <= '0;
                end
                CMD: if (cs_rise) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                end else if (rise) begin
                    cnt <= cnt + 1'b1;
                    cmd <= next_cmd[ADDR_WIDTH-1:0];
                    if (cnt == LAST_CMD) begin
                        if (next_cmd[ADDR_WIDTH]) begin
                            state   <= R_LOAD;
                            rd_req  <= 1'b1;
                            rd_addr <= next_cmd[ADDR_WIDTH-1:0];
                            lph     <= '0;
                        end else begin
                            state <= W_DATA;
                        end
                    end
                end
                // final data edge beats a simultaneous CS rise
                W_DATA: if (rise && cnt == LAST_BIT) begin
                    wr_vld  <= 1'b1;
                    wr_addr <= cmd;
                    wr_data <= next_w;
                    state   <= DONE;
                end else if (cs_rise) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                end else if (rise) begin
                    cnt <= cnt + 1'b1;
                    wsh <= next_w[DATA_WIDTH-2:0];
                end
                R_LOAD: if (cs_rise) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    miso      <= 1'b0;
                end else if (lph == 2'd0) begin
                    lph <= 2'd1;
                end else if (lph == 2'd1) begin
                    rsh <= rd_data;
                    lph <= 2'd2;
                end else if (fall) begin
                    miso  <= rsh[DATA_WIDTH-1];
                    rsh   <= {rsh[DATA_WIDTH-2:0], 1'b0};
                    state <= R_DATA;
                end
                R_DATA: if (cs_rise) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    miso      <= 1'b0;
                end else if (rise) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                        miso  <= 1'b0;
                    end
                end else if (fall) begin
                    miso <= rsh[DATA_WIDTH-1];
                    rsh  <= {rsh[DATA_WIDTH-2:0], 1'b0};
                end
                DONE: begin
                    miso <= 1'b0;
                    if (cs_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_regif.sv
// tb_spi_slave_regif: table-driven SPI master with a scoreboard for write/read strobes and MISO bits
module tb_spi_slave_regif;
    localparam int HALF = 6;

    logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic       miso, wr_vld, rd_req, frame_err;
    logic [2:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    logic [7:0] mem [8];
    logic       rd_q = 1'b0;
    logic [2:0] a_q = '0;
    int         checks = 0, errors = 0;
    int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic       miso_hi = 1'b0;
    logic [10:0] wr_q [$];
    logic [2:0]  rd_q_exp [$];

    typedef struct {
        logic       rw;
        logic [2:0] addr;
        logic [7:0] data;
        int         nbits;
        int         extra;
        int         gap;
        int         exp_wr;
        int         exp_rd;
        int         exp_err;
    } vec_t;
    vec_t vt [10];

    spi_slave_regif dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // register bank returns data only in the clk right after rd_req
    always @(posedge clk) begin
        rd_q <= rd_req;
        a_q  <= rd_addr;
    end
    assign rd_data = rd_q ? mem[a_q] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic b, output logic m);
        mosi = b;
        clks(HALF);
        m    = miso;
        sclk = 1'b1;
        clks(HALF);
        sclk = 1'b0;
    endtask

    always @(negedge clk) if (rst_n) begin
        if (miso) miso_hi = 1'b1;
        if (wr_vld) begin
            wr_cnt++;
            chk("wr_rd_excl", {31'd0, rd_req}, 0);
            if (wr_q.size() > 0) chk("wr_addr_data", {21'd0, wr_addr, wr_data}, {21'd0, wr_q.pop_front()});
        end
        if (rd_req) begin
            rd_cnt++;
            if (rd_q_exp.size() > 0) chk("rd_addr", {29'd0, rd_addr}, {29'd0, rd_q_exp.pop_front()});
        end
        if (frame_err) err_cnt++;
    end

    task automatic run_frame(input vec_t v);
        int w0, r0, e0;
        logic m;
        logic [11:0] bits;
        bits = {v.rw, v.addr, v.data};
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        if (v.exp_wr != 0) wr_q.push_back({v.addr, v.data});
        if (v.exp_rd != 0) rd_q_exp.push_back(v.addr);
        if (v.rw) mem[v.addr] = v.data;
        miso_hi = 1'b0;
        cs = 1'b0;
        clks(4);
        for (int i = 0; i < v.nbits; i++) begin
            pulse(bits[11-i], m);
            if (v.rw && i >= 4 && i < 12) chk("miso_bit", {31'd0, m}, {31'd0, v.data[11-i]});
        end
        for (int i = 0; i < v.extra; i++) pulse(1'b1, m);
        clks(3);
        cs = 1'b1;
        clks(v.gap);
        chk("wr_count", wr_cnt - w0, v.exp_wr);
        chk("rd_count", rd_cnt - r0, v.exp_rd);
        chk("err_count", err_cnt - e0, v.exp_err);
        if (!v.rw) chk("miso_quiet", {31'd0, miso_hi}, 0);
    endtask

    initial begin
        logic m;
        int r0, e0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        //            rw    addr  data   nb ex gap wr rd err
        vt[0] = '{1'b0, 3'd5, 8'hA5, 12, 0, 8, 1, 0, 0};
        vt[1] = '{1'b1, 3'd2, 8'h3C, 12, 0, 8, 0, 1, 0};
        vt[2] = '{1'b0, 3'd0, 8'h00, 12, 0, 8, 1, 0, 0};
        vt[3] = '{1'b0, 3'd1, 8'hF0,  6, 0, 8, 0, 0, 1};
        vt[4] = '{1'b0, 3'd1, 8'h0F, 12, 0, 8, 1, 0, 0};
        vt[5] = '{1'b0, 3'd3, 8'h66, 12, 4, 8, 1, 0, 0};
        vt[6] = '{1'b0, 3'd7, 8'hFF, 12, 0, 4, 1, 0, 0};
        vt[7] = '{1'b1, 3'd7, 8'h81, 12, 0, 8, 0, 1, 0};
        vt[8] = '{1'b1, 3'd4, 8'hC3,  8, 0, 8, 0, 1, 1};
        vt[9] = '{1'b0, 3'd6, 8'h3C, 12, 0, 8, 1, 0, 0};

        clks(3);
        chk("reset_outs", {11'd0, miso, wr_vld, rd_req, frame_err, wr_addr, wr_data, rd_addr}, 0);
        rst_n = 1'b1;
        clks(8);

        for (int k = 0; k < 10; k++) run_frame(vt[k]);

        // reset asserted in the middle of a read frame with CS held low
        mem[3] = 8'h5A;
        rd_q_exp.push_back(3'd3);
        r0 = rd_cnt;
        cs = 1'b0;
        clks(4);
        pulse(1'b1, m);
        pulse(1'b0, m);
        pulse(1'b1, m);
        pulse(1'b1, m);
        pulse(1'b0, m);
        chk("rst_frame_bit0", {31'd0, m}, 0);
        pulse(1'b0, m);
        chk("rst_frame_bit1", {31'd0, m}, 1);
        chk("rst_frame_rdreq", rd_cnt - r0, 1);
        clks(2);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", {11'd0, miso, wr_vld, rd_req, frame_err, wr_addr, wr_data, rd_addr}, 0);
        clks(2);
        rst_n = 1'b1;
        miso_hi = 1'b0;
        r0 = rd_cnt; e0 = err_cnt;
        for (int i = 0; i < 6; i++) pulse(1'b1, m);
        clks(3);
        cs = 1'b1;
        clks(8);
        chk("post_rst_rdreq", rd_cnt - r0, 0);
        chk("post_rst_err", err_cnt - e0, 0);
        chk("post_rst_miso", {31'd0, miso_hi}, 0);
        run_frame('{1'b1, 3'd3, 8'h5A, 12, 0, 8, 0, 1, 0});

        chk("wr_q_empty", wr_q.size(), 0);
        chk("rd_q_empty", rd_q_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
